ddr3_cmd_arbiter: RTL
=====================

# ddr3_cmd_arbiter

Shares the single DDR3 IP user command/data interface between a write requester (capture path) and a read requester (readout path). Arbitration is round-robin, and no grant is issued before DDR initialisation completes. Each granted transaction is expanded into N single-beat commands at incrementing addresses. Completion is signalled only after all write data has been taken, or after all read data has returned.

## Interface
- ADDR_W, 26: DDR IP address width.
- DATA_W, 64: local data width.
- ADDR_STEP, 8: address increment per command.
- i_clk  in  1  system clock, same domain as the DDR IP user side.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_ddr_init_done  in  1  DDR IP initialisation complete (level).
- i_wr_req  in  1  write request; held until o_wr_grant.
- i_wr_addr  in  ADDR_W  write start address.
- i_wr_len  in  8  write command count; 0 means 256.
- o_wr_grant  out  1  one-cycle pulse; addr/len latched.
- o_wr_data_req  out  1  data beat consumed this cycle; requester advances.
- i_wr_data  in  DATA_W  write data, show-ahead.
- o_wr_done  out  1  one-cycle pulse, last beat consumed.
- i_rd_req  in  1  read request; held until o_rd_grant.
- i_rd_addr  in  ADDR_W  read start address.
- i_rd_len  in  8  read command count; 0 means 256.
- o_rd_grant  out  1  one-cycle pulse.
- o_rd_data  out  DATA_W  read data, registered.
- o_rd_data_vld  out  1  o_rd_data valid.
- o_rd_done  out  1  one-cycle pulse, all read data returned.
- o_cmd  out  4  to IP: 4'b0010 WRITE, 4'b0001 READ, 4'b0000 idle.
- o_cmd_valid  out  1  command valid to IP.
- o_addr  out  ADDR_W  command address.
- i_cmd_rdy  in  1  IP accepts command when high with o_cmd_valid.
- i_datain_rdy  in  1  IP takes write data this cycle.
- o_write_data  out  DATA_W  equals i_wr_data (combinational).
- i_read_data  in  DATA_W  IP read data.
- i_read_data_valid  in  1  IP read data strobe.

## Operation
- FSM states: IDLE, WR_CMD, WR_DATA, RD_CMD, RD_WAIT.
- IDLE
  - No grant while i_ddr_init_done=0.
  - When at least one request is pending, register the grant pulse and latch the address and remaining count: rem = (len==0) ? 256 : len, 9 bits.
  - Then go to WR_CMD or RD_CMD.
- Round-robin: on a tie, grant the port not granted last. The last-granted flag resets to "read", so the first tie goes to write.
- Requests are ignored while not in IDLE. A requester may drop its request after the grant.
- WR_CMD
  - Drive o_cmd_valid=1, o_cmd=WRITE, o_addr=cur.
  - On i_cmd_rdy, go to WR_DATA.
- WR_DATA
  - o_wr_data_req = i_datain_rdy, combinational.
  - On i_datain_rdy with rem==1: o_wr_done pulses next cycle, go to IDLE.
  - On i_datain_rdy otherwise: cur += ADDR_STEP, rem--, go to WR_CMD.
- RD_CMD
  - Drive o_cmd_valid=1, o_cmd=READ.
  - On accept: outstanding++, cur += ADDR_STEP, rem--.
  - When rem reaches 0, go to RD_WAIT; otherwise commands continue back-to-back.
- RD_WAIT: when outstanding==0 (including the decrement this cycle), o_rd_done pulses, go to IDLE.
- Read data path
  - Any cycle with i_read_data_valid sets o_rd_data<=i_read_data and o_rd_data_vld<=1, 1-cycle latency.
  - outstanding-- on each strobe. Simultaneous accept and strobe leaves outstanding unchanged.
  - outstanding is 9 bits and never underflows. A strobe with outstanding==0 still forwards data but does not decrement.
- Address arithmetic wraps modulo 2^ADDR_W.
- i_ddr_init_done falling mid-transaction: the current transaction completes; only new grants are gated.
- Reset mid-operation
  - FSM returns to IDLE; counters and outstanding clear.
  - No done pulse is issued for the aborted transaction.

## Timing
- Reset values: every output 0, o_cmd=4'b0000, o_addr=0; o_write_data follows i_wr_data.
- Request to grant: a request sampled in IDLE at edge k gives grant high in cycle k+1. o_cmd_valid is first high in cycle k+2.
- o_cmd_valid and o_addr are registered and held stable until i_cmd_rdy.
- Back-to-back read commands: one per cycle while i_cmd_rdy=1.
- Done pulses are registered and last exactly one cycle. The next grant is possible in the cycle after the done pulse.

## Test plan
- i_ddr_init_done=0, i_wr_req=1 for 100 cycles -> no grant. Assert init_done -> o_wr_grant pulse on the next edge.
- Write: addr=0x100, len=3, i_cmd_rdy and i_datain_rdy always 1 -> WRITE commands at 0x100, 0x108, 0x110; 3 o_wr_data_req; one o_wr_done.
- Read: addr=0x3FFFFF8, len=2 -> addresses 0x3FFFFF8 then 0x0000000 (wrap). Return 2 strobes with delay 10 -> o_rd_data matches one cycle later; o_rd_done after the second strobe.
- Both requests held high continuously, len=1 each -> grants alternate W, R, W, R.
- Read len=0 with i_cmd_rdy toggling 50% -> exactly 256 READ commands; outstanding is correct under simultaneous accept and strobe; done after the 256th strobe.
- Reset asserted in WR_DATA after 1 of 4 beats -> all outputs 0 immediately, no o_wr_done. After release, a new request is granted normally.

Source files
------------

// File: rtl/ddr3_cmd_arbiter.sv
// ddr3_cmd_arbiter: shares one DDR3 IP user command/data port between a
// write requester and a read requester. Round-robin arbitration, gated by
// DDR initialisation; each grant expands into single-beat commands at
// incrementing addresses, with completion after the last data beat.
module ddr3_cmd_arbiter #(
  parameter int ADDR_W    = 26,
  parameter int DATA_W    = 64,
  parameter int ADDR_STEP = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ddr_init_done,
  // write requester
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_len,
  output logic              o_wr_grant,
  output logic              o_wr_data_req,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_done,
  // read requester
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [7:0]        i_rd_len,
  output logic              o_rd_grant,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_data_vld,
  output logic              o_rd_done,
  // DDR IP user side
  output logic [3:0]        o_cmd,
  output logic              o_cmd_valid,
  output logic [ADDR_W-1:0] o_addr,
  input  logic              i_cmd_rdy,
  input  logic              i_datain_rdy,
  output logic [DATA_W-1:0] o_write_data,
  input  logic [DATA_W-1:0] i_read_data,
  input  logic              i_read_data_valid
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_WR_CMD  = 3'd1;
  localparam logic [2:0] S_WR_DATA = 3'd2;
  localparam logic [2:0] S_RD_CMD  = 3'd3;
  localparam logic [2:0] S_RD_WAIT = 3'd4;

  localparam logic [3:0] CMD_IDLE  = 4'b0000;
  localparam logic [3:0] CMD_READ  = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  logic [2:0]        state;
  logic [ADDR_W-1:0] cur;          // address of the command being issued
  logic [8:0]        rem;          // commands still to issue (1..256)
  logic [8:0]        outstanding;  // read commands accepted, data not yet back
  logic [8:0]        out_next;
  logic              last_rd;      // 1 when the most recent grant went to read
  logic              rd_acc;
  logic              rd_dec;
  logic              pick_wr;
  logic              grant_ok;

  // Arbitration decision and outstanding-read bookkeeping.
  always_comb begin
    rd_acc   = (state == S_RD_CMD) && o_cmd_valid && i_cmd_rdy;
    // A stray strobe with nothing outstanding is forwarded but never counted.
    rd_dec   = i_read_data_valid && (outstanding != 9'd0);
    out_next = outstanding + {8'd0, rd_acc} - {8'd0, rd_dec};
    pick_wr  = i_wr_req && (!i_rd_req || last_rd);
    grant_ok = (state == S_IDLE) && i_ddr_init_done && (i_wr_req || i_rd_req);
  end

  assign o_wr_data_req = (state == S_WR_DATA) && i_datain_rdy;
  assign o_write_data  = i_wr_data;

  // Main controller: grants, command issue, address/count stepping, done pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      cur         <= '0;
      rem         <= '0;
      outstanding <= '0;
      last_rd     <= 1'b1;
      o_wr_grant  <= 1'b0;
      o_rd_grant  <= 1'b0;
      o_wr_done   <= 1'b0;
      o_rd_done   <= 1'b0;
      o_cmd_valid <= 1'b0;
      o_cmd       <= CMD_IDLE;
      o_addr      <= '0;
    end else begin
      o_wr_grant  <= 1'b0;
      o_rd_grant  <= 1'b0;
      o_wr_done   <= 1'b0;
      o_rd_done   <= 1'b0;
      outstanding <= out_next;
      case (state)
        S_IDLE: begin
          if (grant_ok) begin
            last_rd <= !pick_wr;
            if (pick_wr) begin
              o_wr_grant <= 1'b1;
              cur        <= i_wr_addr;
              rem        <= (i_wr_len == 8'd0) ? 9'd256 : {1'b0, i_wr_len};
              state      <= S_WR_CMD;
            end else begin
              o_rd_grant <= 1'b1;
              cur        <= i_rd_addr;
              rem        <= (i_rd_len == 8'd0) ? 9'd256 : {1'b0, i_rd_len};
              state      <= S_RD_CMD;
            end
          end
        end
        S_WR_CMD: begin
          if (!o_cmd_valid) begin
            o_cmd_valid <= 1'b1;
            o_cmd       <= CMD_WRITE;
            o_addr      <= cur;
          end else if (i_cmd_rdy) begin
            o_cmd_valid <= 1'b0;
            o_cmd       <= CMD_IDLE;
            state       <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (i_datain_rdy) begin
            if (rem == 9'd1) begin
              o_wr_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              cur   <= cur + STEP;
              rem   <= rem - 9'd1;
              state <= S_WR_CMD;
            end
          end
        end
        S_RD_CMD: begin
          if (!o_cmd_valid) begin
            o_cmd_valid <= 1'b1;
            o_cmd       <= CMD_READ;
            o_addr      <= cur;
          end else if (i_cmd_rdy) begin
            cur <= cur + STEP;
            rem <= rem - 9'd1;
            if (rem == 9'd1) begin
              o_cmd_valid <= 1'b0;
              o_cmd       <= CMD_IDLE;
              state       <= S_RD_WAIT;
            end else begin
              // keep valid high so reads issue back-to-back
              o_addr <= cur + STEP;
            end
          end
        end
        S_RD_WAIT: begin
          if (out_next == 9'd0) begin
            o_rd_done <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read return path: one-cycle registered forward of IP read data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data     <= '0;
      o_rd_data_vld <= 1'b0;
    end else begin
      o_rd_data_vld <= i_read_data_valid;
      if (i_read_data_valid) o_rd_data <= i_read_data;
    end
  end

endmodule
